// File: rtl/vram_arbiter_pkg.sv
// Shared widths, screen geometry and grant encodings for the VRAM arbiter slice.
package vram_pkg;

    localparam int unsigned ADDR_W   = 18;
    localparam int unsigned DATA_W   = 12;
    localparam int unsigned H_ACTIVE = 512;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned ROW_W    = 9;
    localparam int unsigned COL_W    = 10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DISP = 2'd1,
        S_WR   = 2'd2,
        S_RD   = 2'd3
    } grant_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    function automatic logic is_active(input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col);
        return (col < COL_W'(H_ACTIVE)) && (row < ROW_W'(V_ACTIVE));
    endfunction

    // H_ACTIVE is 512, so the linear pixel address is a plain concatenation.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [ROW_W-1:0] row, input logic [8:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Scan timing, VRAM port and CPU bridge signals seen by the arbiter.
interface vram_arbiter_if;
    import vram_pkg::*;

    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [DATA_W-1:0] vga_data;
    logic [ADDR_W-1:0] vram_addr;
    logic              vram_we;
    logic [DATA_W-1:0] vram_din;
    logic [DATA_W-1:0] vram_dout;
    logic              cpu_wr_req;
    logic [ADDR_W-1:0] cpu_wr_addr;
    logic [DATA_W-1:0] cpu_wr_data;
    logic              cpu_wr_ready;
    logic              cpu_rd_req;
    logic [ADDR_W-1:0] cpu_rd_addr;
    logic              cpu_rd_valid;
    logic [DATA_W-1:0] cpu_rd_data;

    modport slave (
        input  row, col, vram_dout,
        input  cpu_wr_req, cpu_wr_addr, cpu_wr_data, cpu_rd_req, cpu_rd_addr,
        output vga_data, vram_addr, vram_we, vram_din,
        output cpu_wr_ready, cpu_rd_valid, cpu_rd_data
    );

    modport master (
        output row, col, vram_dout,
        output cpu_wr_req, cpu_wr_addr, cpu_wr_data, cpu_rd_req, cpu_rd_addr,
        input  vga_data, vram_addr, vram_we, vram_din,
        input  cpu_wr_ready, cpu_rd_valid, cpu_rd_data
    );

endinterface

// File: rtl/vram_arbiter_wr_fifo.sv
// Synchronous FIFO buffering CPU writes ({addr,data}) until the display blanks.
module vram_wr_fifo
    import vram_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_push,
    input  wr_entry_t i_push_data,
    input  logic      i_pop,
    output wr_entry_t o_pop_data,
    output logic      o_full,
    output logic      o_empty
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wr_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full     = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign w_push     = i_push && !o_full;
    assign w_pop      = i_pop && !o_empty;
    assign o_pop_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scan-out owns the active region, buffered CPU writes
// then CPU reads share the blanking interval.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    vram_arbiter_if.slave bus
);
    grant_e            r_grant;
    grant_e            w_grant;
    grant_e            r_src2;
    logic              r_rd_inflight;
    logic              w_active;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_push;
    logic              w_pop;
    wr_entry_t         w_push_entry;
    wr_entry_t         w_head;
    logic [ADDR_W-1:0] r_vram_addr;
    logic              r_vram_we;
    logic [DATA_W-1:0] r_vram_din;
    logic [DATA_W-1:0] r_vga_data;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;

    assign w_active     = is_active(bus.row, bus.col);
    assign w_push       = bus.cpu_wr_req && !w_fifo_full;
    assign w_pop        = (w_grant == S_WR);
    assign w_push_entry = '{addr: bus.cpu_wr_addr, data: bus.cpu_wr_data};

    vram_wr_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_wr_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_push_data(w_push_entry),
        .i_pop      (w_pop),
        .o_pop_data (w_head),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty)
    );

    always_comb begin
        w_grant = S_IDLE;
        if (w_active)                              w_grant = S_DISP;
        else if (!w_fifo_empty)                    w_grant = S_WR;
        else if (bus.cpu_rd_req && !r_rd_inflight) w_grant = S_RD;
    end

    // r_grant doubles as stage 1 of the return-data source pipe; r_src2 is stage 2.
    always_ff @(posedge clk) begin
        if (rst) r_grant <= S_IDLE;
        else     r_grant <= w_grant;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_src2        <= S_IDLE;
            r_rd_inflight <= 1'b0;
            r_vram_addr   <= '0;
            r_vram_we     <= 1'b0;
            r_vram_din    <= '0;
            r_vga_data    <= '0;
            r_rd_valid    <= 1'b0;
            r_rd_data     <= '0;
        end else begin
            r_src2    <= r_grant;
            r_vram_we <= 1'b0;
            case (w_grant)
                S_DISP: r_vram_addr <= pix_addr(bus.row, bus.col[8:0]);
                S_WR: begin
                    r_vram_addr <= w_head.addr;
                    r_vram_din  <= w_head.data;
                    r_vram_we   <= 1'b1;
                end
                S_RD:    r_vram_addr <= bus.cpu_rd_addr;
                default: r_vram_addr <= r_vram_addr;
            endcase
            r_vga_data <= (r_src2 == S_DISP) ? bus.vram_dout : '0;
            r_rd_valid <= (r_src2 == S_RD);
            if (r_src2 == S_RD) r_rd_data <= bus.vram_dout;
            if (w_grant == S_RD)     r_rd_inflight <= 1'b1;
            else if (r_src2 == S_RD) r_rd_inflight <= 1'b0;
        end
    end

    assign bus.vga_data     = r_vga_data;
    assign bus.vram_addr    = r_vram_addr;
    assign bus.vram_we      = r_vram_we;
    assign bus.vram_din     = r_vram_din;
    assign bus.cpu_wr_ready = !w_fifo_full;
    assign bus.cpu_rd_valid = r_rd_valid;
    assign bus.cpu_rd_data  = r_rd_data;

endmodule
